// File: rtl/pwm_seq_pkg.sv
// Shared types and field layout for the PWM tone sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_seq_pkg;

   localparam int DIV_W   = 12;   // divider field, entry bits [15:4]
   localparam int DUR_W   = 4;    // duration field, entry bits [3:0]
   localparam int ENTRIES = 16;
   localparam int IDX_W   = 4;
   localparam int ENTRY_W = DIV_W + DUR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2,
      GAP  = 2'd3
   } seq_state_e;

   // Packed so a raw 16-bit write word maps straight onto the fields.
   typedef struct packed {
      logic [DIV_W-1:0] div;
      logic [DUR_W-1:0] dur;
   } note_t;

endpackage

// File: rtl/seq_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_CYCLES enabled cycles.
// Latency: tick is a decode of the counter, asserted in the last cycle of each period.
// Backpressure: none; clr restarts the period and wins over en.
//
// Ports: clk, rst_n (async active-low), clr (sync clear), en (count enable),
//        tick (period-complete strobe, only while en and not clr).
module seq_tick_gen #(
   parameter int unsigned TICK_CYCLES = 2500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = en && !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/pwm_tone_sequencer.sv
// Steps through a 16-entry note table, driving the pwm_sine divider and a tone gate.
// Latency: start sampled at edge T -> LOAD in T+1 -> divider/tone_on valid from T+2; all outputs registered.
// Backpressure: none; start is ignored while busy, stop aborts to IDLE on the next cycle.
//
// Ports: clk, rst_n (async active-low); wr_en/wr_addr/wr_data table write
//        ([15:4] divider, [3:0] duration ticks); start, stop, loop control;
//        divider, tone_on, busy, step_idx, done (one-cycle end-of-sequence pulse).
module pwm_tone_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 2500000,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic               start,
   input  logic               stop,
   input  logic               loop,
   output logic [DIV_W-1:0]   divider,
   output logic               tone_on,
   output logic               busy,
   output logic [IDX_W-1:0]   step_idx,
   output logic               done
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

   note_t            note_tab [ENTRIES];
   note_t            cur;
   seq_state_e       state, state_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic [DIV_W-1:0] div_nxt;
   logic             tone_nxt;
   logic             done_nxt;
   logic [DUR_W-1:0] dur_cnt, dur_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic             tick_clr, tick_en, tick;
   logic             eos;

   seq_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tick_clr),
      .en    (tick_en),
      .tick  (tick)
   );

   // The table is a plain flop array; a write in the same cycle as a LOAD
   // lands at the edge, so the LOAD decode sees the pre-write entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) note_tab[i] <= '0;
      end else if (wr_en) begin
         note_tab[wr_addr] <= note_t'(wr_data);
      end
   end

   assign cur = note_tab[step_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         step_idx <= '0;
         divider  <= '0;
         tone_on  <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         dur_cnt  <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         step_idx <= idx_nxt;
         divider  <= div_nxt;
         tone_on  <= tone_nxt;
         done     <= done_nxt;
         busy     <= (state_nxt != IDLE);
         dur_cnt  <= dur_nxt;
         gap_cnt  <= gap_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = step_idx;
      div_nxt   = divider;
      tone_nxt  = tone_on;
      done_nxt  = 1'b0;
      dur_nxt   = dur_cnt;
      gap_nxt   = gap_cnt;
      tick_clr  = 1'b0;
      tick_en   = 1'b0;
      eos       = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
               idx_nxt   = '0;
            end
         end
         LOAD: begin
            if (cur.dur == '0) begin
               eos = 1'b1;
            end else begin
               div_nxt   = cur.div;
               tone_nxt  = (cur.div != '0);
               dur_nxt   = cur.dur;
               tick_clr  = 1'b1;
               state_nxt = PLAY;
            end
         end
         PLAY: begin
            tick_en = 1'b1;
            if (tick) begin
               if (dur_cnt == DUR_W'(1)) begin
                  state_nxt = GAP;
                  tone_nxt  = 1'b0;
                  gap_nxt   = '0;
               end else begin
                  dur_nxt = dur_cnt - 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               // Past the last entry there is no marker to read, so end here.
               if (step_idx == IDX_LAST) begin
                  eos = 1'b1;
               end else begin
                  idx_nxt   = step_idx + 1'b1;
                  state_nxt = LOAD;
               end
            end else begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Looping from entry 0 would re-read the same marker forever, so an
      // empty table always terminates.
      if (eos) begin
         if (loop && (step_idx != '0)) begin
            state_nxt = LOAD;
            idx_nxt   = '0;
         end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            idx_nxt   = '0;
            div_nxt   = '0;
            tone_nxt  = 1'b0;
         end
      end

      if (stop) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         div_nxt   = '0;
         tone_nxt  = 1'b0;
         done_nxt  = 1'b0;
      end
   end

endmodule
